wb_commit_stage: RTL and testbench

Write-back stage at the far end of the MEM/WB pipeline register. Consumes the registered MEM/WB bundle and the data-bus read response. Produces the regfile and HI/LO write ports and the retirement trace. Contains the sequential logic that makes this work:
- a load-wait FSM that raises a stall request until the read data arrives;
- a one-entry early-response buffer for read data that arrives before its load reaches WB;
- a retire-once guard, so an instruction held in MEM/WB by a pipeline stall commits exactly once.

---
 rtl/wb_commit_stage_if.sv | 50 +++++
 rtl/wb_commit_stage.sv | 110 +++++++++++
 tb/tb_wb_commit_stage.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_commit_stage_if.sv
// Bundle between the MEM/WB pipeline register / data bus and the write-back stage.
// The master side drives the MEM/WB fields and bus response; the slave side (WB) drives the write ports.
interface wb_commit_stage_if;
  logic [31:0] wb_pc;
  logic [31:0] wb_inst;
  logic [31:0] wb_res;
  logic        wb_load;
  logic        wb_loadX;
  logic [3:0]  wb_lsV;
  logic [1:0]  wb_data_addr;
  logic        wb_al;
  logic        wb_regwen;
  logic [4:0]  wb_wreg;
  logic        wb_cp0ren;
  logic [31:0] wb_cp0rdata;
  logic [1:0]  wb_hiloren;
  logic [1:0]  wb_hilowen;
  logic [31:0] wb_hilordata;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        pipe_stall;

  logic        wb_stall_req;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        hi_wen;
  logic        lo_wen;
  logic [31:0] hilo_wdata;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  modport master (
    output wb_pc, wb_inst, wb_res, wb_load, wb_loadX, wb_lsV, wb_data_addr, wb_al,
           wb_regwen, wb_wreg, wb_cp0ren, wb_cp0rdata, wb_hiloren, wb_hilowen,
           wb_hilordata, data_data_ok, data_rdata, pipe_stall,
    input  wb_stall_req, rf_wen, rf_waddr, rf_wdata, hi_wen, lo_wen, hilo_wdata,
           debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
  );

  modport slave (
    input  wb_pc, wb_inst, wb_res, wb_load, wb_loadX, wb_lsV, wb_data_addr, wb_al,
           wb_regwen, wb_wreg, wb_cp0ren, wb_cp0rdata, wb_hiloren, wb_hilowen,
           wb_hilordata, data_data_ok, data_rdata, pipe_stall,
    output wb_stall_req, rf_wen, rf_waddr, rf_wdata, hi_wen, lo_wen, hilo_wdata,
           debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
  );
endinterface

// File: rtl/wb_commit_stage.sv
// Write-back stage: commits the MEM/WB instruction to GPR/HI/LO exactly once,
// stalls loads until read data arrives, and buffers read data that shows up early.
module wb_commit_stage (
  input logic              clk,
  input logic              reset,
  wb_commit_stage_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_LOAD = 2'd1, DONE = 2'd2} state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [31:0] r_rbuf;
  logic        r_rbufValid;

  logic        w_valid;
  logic        w_pending;
  logic        w_haveData;
  logic        w_commit;
  logic        w_rbufUsed;
  logic        w_busConsumed;
  logic [31:0] w_loadSrc;
  logic [31:0] w_loadRaw;
  logic [31:0] w_loadData;
  logic [31:0] w_rfWdata;
  logic        w_rfWen;

  assign w_valid    = (bus.wb_pc != 32'd0);
  assign w_haveData = r_rbufValid | bus.data_data_ok;
  // Reset masks everything so a stale MEM/WB bundle cannot write during reset.
  assign w_pending  = !reset && w_valid && (r_state != DONE);
  assign w_commit   = w_pending && (!bus.wb_load || w_haveData);
  assign bus.wb_stall_req = w_pending && bus.wb_load && !w_haveData;

  assign w_rbufUsed    = w_commit && bus.wb_load && r_rbufValid;
  assign w_busConsumed = w_commit && bus.wb_load && !r_rbufValid && bus.data_data_ok;

  assign w_loadSrc = r_rbufValid ? r_rbuf : bus.data_rdata;
  assign w_loadRaw = w_loadSrc >> {bus.wb_data_addr, 3'b000};

  always_comb begin
    w_loadData = w_loadRaw;
    case (bus.wb_lsV)
      4'b0001: w_loadData = {{24{bus.wb_loadX & w_loadRaw[7]}}, w_loadRaw[7:0]};
      4'b0011: w_loadData = {{16{bus.wb_loadX & w_loadRaw[15]}}, w_loadRaw[15:0]};
      default: w_loadData = w_loadRaw;
    endcase
  end

  always_comb begin
    w_rfWdata = bus.wb_res;
    if (bus.wb_load)                w_rfWdata = w_loadData;
    else if (bus.wb_cp0ren)         w_rfWdata = bus.wb_cp0rdata;
    else if (bus.wb_hiloren != 2'b00) w_rfWdata = bus.wb_hilordata;
    else if (bus.wb_al)             w_rfWdata = bus.wb_res;
  end

  // Once committed under a stall, DONE blocks recommit until the pipeline moves.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_commit)
          w_nextState = bus.pipe_stall ? DONE : IDLE;
        else if (w_valid && bus.wb_load && !w_haveData)
          w_nextState = WAIT_LOAD;
      end
      WAIT_LOAD: begin
        if (w_commit)
          w_nextState = bus.pipe_stall ? DONE : IDLE;
      end
      DONE: begin
        if (!bus.pipe_stall)
          w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rbuf      <= 32'd0;
      r_rbufValid <= 1'b0;
    end else begin
      r_state <= w_nextState;
      // A fresh response wins over clearing, so a consume-and-refill keeps the buffer full.
      if (bus.data_data_ok && !w_busConsumed) begin
        r_rbuf      <= bus.data_rdata;
        r_rbufValid <= 1'b1;
      end else if (w_rbufUsed) begin
        r_rbufValid <= 1'b0;
      end
    end
  end

  assign w_rfWen = w_commit && bus.wb_regwen && (bus.wb_wreg != 5'd0);

  assign bus.rf_wen            = w_rfWen;
  assign bus.rf_waddr          = bus.wb_wreg;
  assign bus.rf_wdata          = w_rfWdata;
  assign bus.hi_wen            = w_commit && bus.wb_hilowen[1];
  assign bus.lo_wen            = w_commit && bus.wb_hilowen[0];
  assign bus.hilo_wdata        = bus.wb_res;
  assign bus.debug_wb_pc       = bus.wb_pc;
  assign bus.debug_wb_rf_wen   = {4{w_rfWen}};
  assign bus.debug_wb_rf_wnum  = bus.wb_wreg;
  assign bus.debug_wb_rf_wdata = w_rfWdata;

endmodule

// File: tb/tb_wb_commit_stage.sv
// Directed bench for wb_commit_stage: single-cycle vector table plus
// hand-written sequences for load waits, early responses, retire-once and reset.
module tb_wb_commit_stage;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wb_commit_stage_if bus ();

  wb_commit_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    string       name;
    logic [31:0] pc, res, cp0rdata, hilordata, rdata;
    logic        load, loadX, regwen, cp0ren, dataOk, al;
    logic [3:0]  lsV;
    logic [1:0]  addr, hiloren, hilowen;
    logic [4:0]  wreg;
    logic        expWen, expHi, expLo, expStall;
    logic [31:0] expWdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t blankVec();
    vec_t v;
    v.name = ""; v.pc = 0; v.res = 0; v.cp0rdata = 0; v.hilordata = 0; v.rdata = 0;
    v.load = 0; v.loadX = 0; v.regwen = 0; v.cp0ren = 0; v.dataOk = 0; v.al = 0;
    v.lsV = 4'b1111; v.addr = 0; v.hiloren = 0; v.hilowen = 0; v.wreg = 0;
    v.expWen = 0; v.expHi = 0; v.expLo = 0; v.expStall = 0; v.expWdata = 0;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clearInputs();
    bus.wb_pc = 0; bus.wb_inst = 0; bus.wb_res = 0; bus.wb_load = 0; bus.wb_loadX = 0;
    bus.wb_lsV = 4'b1111; bus.wb_data_addr = 0; bus.wb_al = 0; bus.wb_regwen = 0;
    bus.wb_wreg = 0; bus.wb_cp0ren = 0; bus.wb_cp0rdata = 0; bus.wb_hiloren = 0;
    bus.wb_hilowen = 0; bus.wb_hilordata = 0; bus.data_data_ok = 0; bus.data_rdata = 0;
    bus.pipe_stall = 0;
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.wb_pc = v.pc; bus.wb_inst = 32'h0; bus.wb_res = v.res; bus.wb_load = v.load;
    bus.wb_loadX = v.loadX; bus.wb_lsV = v.lsV; bus.wb_data_addr = v.addr; bus.wb_al = v.al;
    bus.wb_regwen = v.regwen; bus.wb_wreg = v.wreg; bus.wb_cp0ren = v.cp0ren;
    bus.wb_cp0rdata = v.cp0rdata; bus.wb_hiloren = v.hiloren; bus.wb_hilowen = v.hilowen;
    bus.wb_hilordata = v.hilordata; bus.data_data_ok = v.dataOk; bus.data_rdata = v.rdata;
    bus.pipe_stall = 1'b0;
  endtask

  // Drive a load bundle; data response handled separately.
  task automatic setLoad(input logic [31:0] pc, input logic [4:0] wreg, input logic [3:0] lsV,
                         input logic [1:0] addr, input logic loadX);
    bus.wb_pc = pc; bus.wb_load = 1; bus.wb_regwen = 1; bus.wb_wreg = wreg;
    bus.wb_lsV = lsV; bus.wb_data_addr = addr; bus.wb_loadX = loadX;
  endtask

  task automatic setAlu(input logic [31:0] pc, input logic [4:0] wreg, input logic [31:0] res);
    bus.wb_pc = pc; bus.wb_load = 0; bus.wb_regwen = 1; bus.wb_wreg = wreg; bus.wb_res = res;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;

    v = blankVec(); v.name = "alu"; v.pc = 32'hBFC00010; v.regwen = 1; v.wreg = 5; v.res = 32'h1234;
    v.expWen = 1; v.expWdata = 32'h1234; vecs.push_back(v);
    v = blankVec(); v.name = "wreg0"; v.pc = 32'hBFC00014; v.regwen = 1; v.wreg = 0; v.res = 32'h55;
    v.expWdata = 32'h55; vecs.push_back(v);
    v = blankVec(); v.name = "mthi"; v.pc = 32'hBFC00018; v.hilowen = 2'b10; v.res = 32'h77;
    v.expHi = 1; v.expWdata = 32'h77; vecs.push_back(v);
    v = blankVec(); v.name = "mtlo"; v.pc = 32'hBFC0001C; v.hilowen = 2'b01; v.res = 32'h88;
    v.expLo = 1; v.expWdata = 32'h88; vecs.push_back(v);
    v = blankVec(); v.name = "mfc0"; v.pc = 32'hBFC00020; v.regwen = 1; v.wreg = 8; v.res = 32'h1;
    v.cp0ren = 1; v.cp0rdata = 32'hDEADBEEF; v.expWen = 1; v.expWdata = 32'hDEADBEEF; vecs.push_back(v);
    v = blankVec(); v.name = "mflo"; v.pc = 32'hBFC00024; v.regwen = 1; v.wreg = 9; v.res = 32'h2;
    v.hiloren = 2'b01; v.hilordata = 32'h0000ABCD; v.expWen = 1; v.expWdata = 32'h0000ABCD; vecs.push_back(v);
    v = blankVec(); v.name = "bubble"; v.pc = 0; v.regwen = 1; v.wreg = 3; v.hilowen = 2'b11;
    v.res = 32'h42; v.expWdata = 32'h42; vecs.push_back(v);
    v = blankVec(); v.name = "lw"; v.pc = 32'hBFC00028; v.load = 1; v.regwen = 1; v.wreg = 10;
    v.dataOk = 1; v.rdata = 32'h11223344; v.expWen = 1; v.expWdata = 32'h11223344; vecs.push_back(v);
    v = blankVec(); v.name = "lh"; v.pc = 32'hBFC0002C; v.load = 1; v.loadX = 1; v.lsV = 4'b0011;
    v.addr = 2; v.regwen = 1; v.wreg = 11; v.dataOk = 1; v.rdata = 32'h80010000;
    v.expWen = 1; v.expWdata = 32'hFFFF8001; vecs.push_back(v);
    v = blankVec(); v.name = "lhu"; v.pc = 32'hBFC00030; v.load = 1; v.loadX = 0; v.lsV = 4'b0011;
    v.addr = 2; v.regwen = 1; v.wreg = 12; v.dataOk = 1; v.rdata = 32'h80010000;
    v.expWen = 1; v.expWdata = 32'h00008001; vecs.push_back(v);
    v = blankVec(); v.name = "lbu"; v.pc = 32'hBFC00034; v.load = 1; v.lsV = 4'b0001; v.addr = 1;
    v.regwen = 1; v.wreg = 13; v.dataOk = 1; v.rdata = 32'h0000F100;
    v.expWen = 1; v.expWdata = 32'h000000F1; vecs.push_back(v);
    v = blankVec(); v.name = "lbpos"; v.pc = 32'hBFC00038; v.load = 1; v.loadX = 1; v.lsV = 4'b0001;
    v.addr = 3; v.regwen = 1; v.wreg = 14; v.dataOk = 1; v.rdata = 32'h7F000000;
    v.expWen = 1; v.expWdata = 32'h0000007F; vecs.push_back(v);
    v = blankVec(); v.name = "loadprio"; v.pc = 32'hBFC0003C; v.load = 1; v.regwen = 1; v.wreg = 15;
    v.cp0ren = 1; v.cp0rdata = 32'h12345678; v.dataOk = 1; v.rdata = 32'hA5A5A5A5;
    v.expWen = 1; v.expWdata = 32'hA5A5A5A5; vecs.push_back(v);
    v = blankVec(); v.name = "jal"; v.pc = 32'hBFC00040; v.al = 1; v.regwen = 1; v.wreg = 31;
    v.res = 32'hBFC00048; v.expWen = 1; v.expWdata = 32'hBFC00048; vecs.push_back(v);

    // Reset masks writes and stall even with a pending load present.
    clearInputs();
    reset = 1;
    setLoad(32'hBFC00000, 5'd4, 4'b1111, 2'd0, 1'b0);
    bus.wb_hilowen = 2'b11;
    @(negedge clk);
    checkOutput("rst_rfwen", 32'(bus.rf_wen), 32'd0);
    checkOutput("rst_stall", 32'(bus.wb_stall_req), 32'd0);
    checkOutput("rst_hilo", 32'({bus.hi_wen, bus.lo_wen}), 32'd0);
    checkOutput("rst_dbgwen", 32'(bus.debug_wb_rf_wen), 32'd0);
    nextCycle();
    clearInputs();
    nextCycle();
    reset = 0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput({vecs[i].name, "_wen"},   32'(bus.rf_wen), 32'(vecs[i].expWen));
      checkOutput({vecs[i].name, "_wdata"}, bus.rf_wdata, vecs[i].expWdata);
      checkOutput({vecs[i].name, "_waddr"}, 32'(bus.rf_waddr), 32'(vecs[i].wreg));
      checkOutput({vecs[i].name, "_hi"},    32'(bus.hi_wen), 32'(vecs[i].expHi));
      checkOutput({vecs[i].name, "_lo"},    32'(bus.lo_wen), 32'(vecs[i].expLo));
      checkOutput({vecs[i].name, "_stall"}, 32'(bus.wb_stall_req), 32'(vecs[i].expStall));
      checkOutput({vecs[i].name, "_dbgwen"}, 32'(bus.debug_wb_rf_wen), {28'd0, {4{vecs[i].expWen}}});
      checkOutput({vecs[i].name, "_dbgpc"}, bus.debug_wb_pc, vecs[i].pc);
      checkOutput({vecs[i].name, "_hilodata"}, bus.hilo_wdata, vecs[i].res);
      nextCycle();
    end
    clearInputs();

    // Load waits three cycles for its data.
    setLoad(32'hBFC00100, 5'd4, 4'b0001, 2'd2, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("wait_stall", 32'(bus.wb_stall_req), 32'd1);
      checkOutput("wait_wen", 32'(bus.rf_wen), 32'd0);
      nextCycle();
    end
    checkOutput("wait_state", 32'(dut.r_state), 32'd1);
    bus.data_data_ok = 1; bus.data_rdata = 32'h00800000;
    @(negedge clk);
    checkOutput("wait_done_stall", 32'(bus.wb_stall_req), 32'd0);
    checkOutput("wait_done_wen", 32'(bus.rf_wen), 32'd1);
    checkOutput("wait_done_wdata", bus.rf_wdata, 32'hFFFFFF80);
    nextCycle();
    clearInputs();

    // Early response buffered during a bubble, then consumed by the next lw.
    bus.data_data_ok = 1; bus.data_rdata = 32'hCAFEBABE;
    @(negedge clk);
    checkOutput("early_bubble_wen", 32'(bus.rf_wen), 32'd0);
    nextCycle();
    clearInputs();
    checkOutput("early_rbufvalid", 32'(dut.r_rbufValid), 32'd1);
    setLoad(32'hBFC00104, 5'd6, 4'b1111, 2'd0, 1'b0);
    @(negedge clk);
    checkOutput("early_stall", 32'(bus.wb_stall_req), 32'd0);
    checkOutput("early_wen", 32'(bus.rf_wen), 32'd1);
    checkOutput("early_wdata", bus.rf_wdata, 32'hCAFEBABE);
    nextCycle();
    setLoad(32'hBFC00108, 5'd7, 4'b1111, 2'd0, 1'b0);
    @(negedge clk);
    checkOutput("early_cleared_stall", 32'(bus.wb_stall_req), 32'd1);
    nextCycle();
    bus.data_data_ok = 1; bus.data_rdata = 32'h00000005;
    @(negedge clk);
    checkOutput("early_cleared_wdata", bus.rf_wdata, 32'h00000005);
    nextCycle();
    clearInputs();

    // Buffer consumed in the same cycle a new response arrives: new data retained.
    bus.data_data_ok = 1; bus.data_rdata = 32'h00000011;
    nextCycle();
    clearInputs();
    setLoad(32'hBFC0010C, 5'd8, 4'b1111, 2'd0, 1'b0);
    bus.data_data_ok = 1; bus.data_rdata = 32'h00000022;
    @(negedge clk);
    checkOutput("refill_wdata1", bus.rf_wdata, 32'h00000011);
    nextCycle();
    bus.data_data_ok = 0; bus.wb_pc = 32'hBFC00110;
    @(negedge clk);
    checkOutput("refill_stall", 32'(bus.wb_stall_req), 32'd0);
    checkOutput("refill_wdata2", bus.rf_wdata, 32'h00000022);
    nextCycle();
    clearInputs();

    // Retire once across a four-cycle stall.
    setAlu(32'hBFC00200, 5'd7, 32'h00000099);
    bus.wb_hilowen = 2'b11;
    bus.pipe_stall = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("once_wen", 32'(bus.rf_wen), (k == 0) ? 32'd1 : 32'd0);
      checkOutput("once_hi", 32'(bus.hi_wen), (k == 0) ? 32'd1 : 32'd0);
      nextCycle();
    end
    bus.pipe_stall = 0;
    @(negedge clk);
    checkOutput("once_release_wen", 32'(bus.rf_wen), 32'd0);
    nextCycle();
    checkOutput("once_idle", 32'(dut.r_state), 32'd0);
    setAlu(32'hBFC00204, 5'd9, 32'h000000AA);
    bus.wb_hilowen = 2'b00;
    @(negedge clk);
    checkOutput("once_next_wen", 32'(bus.rf_wen), 32'd1);
    nextCycle();
    clearInputs();

    // Reset while waiting for load data.
    setLoad(32'hBFC00300, 5'd3, 4'b1111, 2'd0, 1'b0);
    @(negedge clk);
    checkOutput("rstw_stall", 32'(bus.wb_stall_req), 32'd1);
    nextCycle();
    reset = 1;
    bus.data_data_ok = 1; bus.data_rdata = 32'h0BADF00D;
    bus.wb_hilowen = 2'b11;
    @(negedge clk);
    checkOutput("rstw_wen", 32'(bus.rf_wen), 32'd0);
    checkOutput("rstw_hilo", 32'({bus.hi_wen, bus.lo_wen}), 32'd0);
    checkOutput("rstw_stall_in_rst", 32'(bus.wb_stall_req), 32'd0);
    nextCycle();
    reset = 0;
    bus.data_data_ok = 0; bus.wb_hilowen = 2'b00;
    checkOutput("rstw_state", 32'(dut.r_state), 32'd0);
    checkOutput("rstw_rbufvalid", 32'(dut.r_rbufValid), 32'd0);
    @(negedge clk);
    checkOutput("rstw_after_stall", 32'(bus.wb_stall_req), 32'd1);
    nextCycle();
    clearInputs();
    nextCycle();

    // Reset in DONE lets the held instruction commit again.
    setAlu(32'hBFC00400, 5'd10, 32'h00000123);
    bus.pipe_stall = 1;
    nextCycle();
    @(negedge clk);
    checkOutput("rstd_done_wen", 32'(bus.rf_wen), 32'd0);
    nextCycle();
    reset = 1;
    nextCycle();
    reset = 0;
    bus.pipe_stall = 0;
    @(negedge clk);
    checkOutput("rstd_recommit_wen", 32'(bus.rf_wen), 32'd1);
    nextCycle();
    clearInputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
